fetch_controller: RTL and testbench

- Sequences the synchronous-read instruction memory (one-cycle registered read, no enable) for the piRISC core.
- Owns the fetch PC and drives the memory word address.
- Tracks which read results are wanted and presents fetched instructions to decode over a valid/ready handshake, through a 2-entry skid buffer.
- Accepts branch/jump redirects from execute, with squash and flush of stale fetches.

---
 rtl/pirisc_pkg.sv | 21 ++
 rtl/fetch_skid_buffer.sv | 98 +++++++++
 rtl/fetch_controller.sv | 90 +++++++++
 tb/tb_fetch_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pirisc_pkg.sv
// ============================================================================
// Module   : pirisc_pkg
// Brief    : Shared types and constants for the piRISC fetch path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pirisc_pkg;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int          IMEM_AWIDTH      = 10;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module   : fetch_skid_buffer
// Brief    : Two-entry {pc, instr} FIFO with a registered head; flush beats enq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buffer
    import pirisc_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_i,
    input  logic [DWIDTH-1:0] enq_instr_i,
    input  logic [DWIDTH-1:0] enq_pc_i,
    input  logic              deq_i,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic              head_valid_o,
    output logic [DWIDTH-1:0] head_instr_o,
    output logic [DWIDTH-1:0] head_pc_o
);

    logic [1:0]        count_q, count_d;
    logic [DWIDTH-1:0] head_instr_q, head_instr_d;
    logic [DWIDTH-1:0] head_pc_q, head_pc_d;
    logic [DWIDTH-1:0] tail_instr_q, tail_instr_d;
    logic [DWIDTH-1:0] tail_pc_q, tail_pc_d;

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({enq_i, deq_i})
                2'b01: begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    count_d      = count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = enq_instr_i;
                        head_pc_d    = enq_pc_i;
                    end else begin
                        tail_instr_d = enq_instr_i;
                        tail_pc_d    = enq_pc_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = enq_instr_i;
                        tail_pc_d    = enq_pc_i;
                    end else begin
                        head_instr_d = enq_instr_i;
                        head_pc_d    = enq_pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_pc_q    <= RESET_PC;
            tail_instr_q <= '0;
            tail_pc_q    <= RESET_PC;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_instr_o = head_instr_q;
    assign head_pc_o    = head_pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module   : fetch_controller
// Brief    : piRISC fetch PC, imem sequencing, redirect squash, skid-buffered output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_controller
    import pirisc_pkg::*;
#(
    parameter int                DWIDTH   = 32,
    parameter int                AWIDTH   = IMEM_AWIDTH,
    parameter logic [DWIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_instr_i,
    input  logic              redirect_valid_i,
    input  logic [DWIDTH-1:0] redirect_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_instr_o,
    output logic [DWIDTH-1:0] out_pc_o
);

    fetch_state_t      state_q;
    logic [DWIDTH-1:0] fetch_pc_q;
    logic [DWIDTH-1:0] inflight_pc_q;
    logic              inflight_q;

    logic [DWIDTH-1:0] issue_pc;
    logic [1:0]        buf_count;
    logic [1:0]        occupancy;
    logic              deq;
    logic              issue;
    logic              enq;
    logic              unused_redirect_lsbs;

    assign issue_pc    = redirect_valid_i ? {redirect_pc_i[DWIDTH-1:2], 2'b00} : fetch_pc_q;
    assign imem_addr_o = issue_pc[AWIDTH+1:2];

    assign occupancy = buf_count + {1'b0, inflight_q};
    assign deq       = out_valid_o & out_ready_i;
    assign issue     = (state_q == RUN) &&
                       (redirect_valid_i || (occupancy < 2'd2) || deq);
    // A redirect squashes the response arriving this cycle.
    assign enq       = inflight_q & ~redirect_valid_i;

    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else if (state_q == BOOT) begin
            state_q    <= RUN;
            inflight_q <= 1'b0;
            fetch_pc_q <= issue_pc;
        end else if (issue) begin
            inflight_q    <= 1'b1;
            inflight_pc_q <= issue_pc;
            fetch_pc_q    <= issue_pc + DWIDTH'(4);
        end else begin
            inflight_q <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .DWIDTH   (DWIDTH),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .enq_i        (enq),
        .enq_instr_i  (imem_instr_i),
        .enq_pc_i     (inflight_pc_q),
        .deq_i        (deq),
        .flush_i      (redirect_valid_i),
        .count_o      (buf_count),
        .head_valid_o (out_valid_o),
        .head_instr_o (out_instr_o),
        .head_pc_o    (out_pc_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
// Module   : tb_fetch_controller
// Brief    : Self-checking bench for fetch_controller with a stream-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    // Stream-level reference: the next PC decode should see, and bookkeeping.
    logic [31:0] exp_pc;
    int          quiet;
    int          since_reset;
    logic        prev_redir;
    logic        prev_hold;

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [9:0]  exp_addr;
    } vec_t;

    vec_t tbl [21];

    fetch_controller #(
        .DWIDTH   (32),
        .AWIDTH   (10),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_instr_o      (out_instr),
        .out_pc_o         (out_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_instr <= mem[imem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] epc, input logic [9:0] ea);
        vec_t v;
        v.ready = rdy; v.redir = rv; v.rpc = rpc;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_addr = ea;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return mem[pc[11:2]];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        exp_pc      = 32'h0;
        quiet       = -2;
        since_reset = 0;
        prev_redir  = 1'b0;
        prev_hold   = 1'b0;
    endtask

    // One clock cycle: drive, then check the stream rules and advance the model.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        logic [31:0] aligned;
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        aligned = {rpc[31:2], 2'b00};
        if (prev_redir) chk("m_flush", 32'(out_valid), 32'd0);
        if (prev_hold)  chk("m_hold_valid", 32'(out_valid), 32'd1);
        if (rv) chk("m_redir_addr", 32'(imem_addr), 32'(rpc[11:2]));
        if (out_valid) begin
            chk("m_pc", out_pc, exp_pc);
            chk("m_instr", out_instr, word_of(out_pc));
            quiet = 0;
        end else begin
            quiet++;
            chk("m_bubble", 32'(quiet > 1), 32'd0);
        end
        prev_hold  = out_valid && !rdy && !rv;
        prev_redir = rv;
        if (out_valid && rdy) exp_pc = exp_pc + 32'd4;
        if (rv) begin
            exp_pc = aligned;
            quiet  = (since_reset == 0) ? -1 : 0;
        end
        since_reset++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = i;

        for (int i = 0; i < 11; i++)
            tbl[i] = mk(1'b1, 1'b0, 32'h0, (i >= 3), 32'(4 * (i - 3)), (i == 0) ? 10'd0 : 10'(i - 1));
        for (int i = 11; i < 17; i++)
            tbl[i] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 10'd10);
        tbl[17] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 10'd10);
        tbl[18] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h24, 10'd11);
        tbl[19] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h28, 10'd12);
        tbl[20] = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h2C, 10'd13);

        // Boot latency, streaming and a six-cycle stall.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].ready, tbl[i].redir, tbl[i].rpc);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
            chk("tbl_addr", 32'(imem_addr), 32'(tbl[i].exp_addr));
            if (tbl[i].exp_valid) begin
                chk("tbl_pc", out_pc, tbl[i].exp_pc);
                chk("tbl_instr", out_instr, word_of(tbl[i].exp_pc));
            end
        end

        // Redirect squashes buffered 0x0C and inflight 0x10.
        do_reset();
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h43);
        chk("sq_pre_pc", out_pc, 32'h0C);
        chk("sq_addr", 32'(imem_addr), 32'd16);
        cycle(1'b1, 1'b0, 32'h0);
        chk("sq_flush", 32'(out_valid), 32'd0);
        chk("sq_addr2", 32'(imem_addr), 32'd17);
        cycle(1'b1, 1'b0, 32'h0);
        chk("sq_valid", 32'(out_valid), 32'd1);
        chk("sq_pc", out_pc, 32'h40);
        chk("sq_instr", out_instr, mem[16]);
        cycle(1'b1, 1'b0, 32'h0);
        chk("sq_pc2", out_pc, 32'h44);

        // Redirect coinciding with a transfer, then address wrap.
        do_reset();
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h100);
        chk("rr_head", out_pc, 32'h08);
        cycle(1'b1, 1'b0, 32'h0);
        chk("rr_gap", 32'(out_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("rr_pc", out_pc, 32'h100);
        chk("rr_instr", out_instr, mem[64]);
        cycle(1'b1, 1'b1, 32'hFF8);
        chk("wr_addr0", 32'(imem_addr), 32'd1022);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wr_addr1", 32'(imem_addr), 32'd1023);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wr_addr2", 32'(imem_addr), 32'd0);
        chk("wr_pc0", out_pc, 32'hFF8);
        chk("wr_instr0", out_instr, mem[1022]);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wr_pc1", out_pc, 32'hFFC);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wr_pc2", out_pc, 32'h1000);
        chk("wr_instr2", out_instr, mem[0]);

        // Redirect while in BOOT.
        do_reset();
        cycle(1'b1, 1'b1, 32'h202);
        cycle(1'b1, 1'b0, 32'h0);
        chk("bt_addr", 32'(imem_addr), 32'd128);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("bt_valid", 32'(out_valid), 32'd1);
        chk("bt_pc", out_pc, 32'h200);
        chk("bt_instr", out_instr, mem[128]);

        // Asynchronous reset with a full buffer, then restart.
        repeat (2) cycle(1'b1, 1'b0, 32'h0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        chk("ar_full_valid", 32'(out_valid), 32'd1);
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("ar_restart_valid", 32'(out_valid), 32'd1);
        chk("ar_restart_pc", out_pc, 32'h0);

        // Randomised traffic against the stream model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
